// File: rtl/mem_layout_pkg.sv
// Shared memory-map layout constants used to size the big-register collectors.
package mem_layout_pkg;
    localparam int WD_DATA_WIDTH = 16;
    localparam int SDC_SAMPLES   = 16;
    localparam int CHAN_SAMPLES  = 2;
    localparam int BATCH_SAMPLES = 16;
endpackage

// File: rtl/ps_bigreg_collector.sv
// Snapshots one multi-entry PS big register into a wide word when its VALID entry
// turns fresh, asks mem_map to clear the group, and holds the word until consumed.
module ps_bigreg_collector
    import mem_layout_pkg::*;
#(
    parameter int SAMPLES = SDC_SAMPLES,
    parameter int WORD_W  = WD_DATA_WIDTH,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SAMPLES:0]          fresh_bits,
    input  logic [SAMPLES*WORD_W-1:0] mem_words,
    output logic [SAMPLES:0]          clr_bits,
    output logic [SAMPLES*WORD_W-1:0] data_out,
    output logic                      data_valid,
    input  logic                      data_ready,
    output logic                      partial,
    output logic [CNT_W-1:0]          partial_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    // Handshake: data_out/partial are offered while data_valid=1 and are taken on
    // any rising clk edge where data_valid & data_ready; data_ready alone is ignored.
    logic [0:0] state;
    logic       cap_partial;

    assign cap_partial = ~&fresh_bits[SAMPLES-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clr_bits    <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            partial     <= 1'b0;
            partial_cnt <= '0;
        end else begin
            clr_bits <= '0;
            case (state)
                IDLE: begin
                    if (fresh_bits[SAMPLES]) begin
                        data_out   <= mem_words;
                        partial    <= cap_partial;
                        data_valid <= 1'b1;
                        clr_bits   <= '1;
                        state      <= HOLD;
                        if (cap_partial && (partial_cnt != {CNT_W{1'b1}}))
                            partial_cnt <= partial_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // Writes landing now keep their fresh bits in mem_map and are
                    // picked up after the return to IDLE.
                    if (data_ready) begin
                        data_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps_bigreg_collector.sv
// Bench for ps_bigreg_collector: directed scenarios plus random traffic against a
// transaction-level model (queue of committed words, handshake bookkeeping).
module tb_ps_bigreg_collector;

    localparam int S  = 16;
    localparam int W  = 16;
    localparam int CW = 8;
    localparam int DW = S * W;

    logic            clk;
    logic            rst;
    logic [S:0]      fresh_bits;
    logic [DW-1:0]   mem_words;
    logic [S:0]      clr_bits;
    logic [DW-1:0]   data_out;
    logic            data_valid;
    logic            data_ready;
    logic            partial;
    logic [CW-1:0]   partial_cnt;

    ps_bigreg_collector #(.SAMPLES(S), .WORD_W(W), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .fresh_bits  (fresh_bits),
        .mem_words   (mem_words),
        .clr_bits    (clr_bits),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .partial     (partial),
        .partial_cnt (partial_cnt)
    );

    // clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // model
    logic [DW-1:0] exp_q[$];
    logic          exp_part_q[$];
    bit            m_clr;
    int            m_cnt;
    int            commits;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_part_q.delete();
        m_clr = 0;
        m_cnt = 0;
    endtask

    // Predict the effect of the coming clock edge from the inputs now applied.
    task automatic model_step();
        m_clr = 0;
        if (exp_q.size() == 0) begin
            if (fresh_bits[S]) begin
                bit p;
                p = ($countones(fresh_bits[S-1:0]) != S);
                exp_q.push_back(mem_words);
                exp_part_q.push_back(p);
                m_clr = 1;
                commits++;
                if (p && m_cnt < 255) m_cnt++;
            end
        end else if (data_ready) begin
            void'(exp_q.pop_front());
            void'(exp_part_q.pop_front());
        end
    endtask

    task automatic compare_outputs();
        logic [DW-1:0] clr_exp;
        clr_exp = m_clr ? DW'({(S+1){1'b1}}) : '0;
        check("data_valid", DW'(data_valid), DW'(exp_q.size() != 0));
        check("clr_bits", DW'(clr_bits), clr_exp);
        check("partial_cnt", DW'(partial_cnt), DW'(m_cnt));
        if (exp_q.size() != 0) begin
            check("data_out", data_out, exp_q[0]);
            check("partial", DW'(partial), DW'(exp_part_q[0]));
        end
    endtask

    // Inputs are set at the negedge; this advances one cycle and checks.
    task automatic tick();
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic set_words_ramp(input int base);
        for (int i = 0; i < S; i++) mem_words[i*W +: W] = W'(base + i);
    endtask

    task automatic set_words_rand();
        for (int i = 0; i < S; i++) mem_words[i*W +: W] = W'($urandom_range(0, 16'hFFFF));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        check("reset_valid", DW'(data_valid), '0);
        check("reset_clr", DW'(clr_bits), '0);
        check("reset_data", data_out, '0);
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        fresh_bits = '0;
        mem_words  = '0;
        data_ready = 1'b0;
        commits    = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: full commit
        set_words_ramp(16'h1000);
        data_ready = 1'b1;
        repeat (3) tick();
        fresh_bits = '1;
        tick();
        check("t1_valid", DW'(data_valid), DW'(1));
        check("t1_clr", DW'(clr_bits), DW'(17'h1FFFF));
        check("t1_entry3", DW'(data_out[3*W +: W]), DW'(16'h1003));
        check("t1_partial", DW'(partial), '0);
        fresh_bits = '0;
        tick();
        check("t1_valid_drop", DW'(data_valid), '0);
        check("t1_clr_drop", DW'(clr_bits), '0);
        tick();

        // 2: partial commit
        set_words_ramp(16'h2000);
        fresh_bits = {1'b1, 8'h00, 8'hFF};
        tick();
        check("t2_partial", DW'(partial), DW'(1));
        check("t2_cnt", DW'(partial_cnt), DW'(1));
        check("t2_entry12", DW'(data_out[12*W +: W]), DW'(16'h200C));
        fresh_bits = '0;
        repeat (2) tick();

        // 3: backpressure with a new write during HOLD
        data_ready = 1'b0;
        set_words_ramp(16'h3000);
        fresh_bits = '1;
        tick();
        fresh_bits = '0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 3) begin
                set_words_ramp(16'h4000);
                fresh_bits = '1;
            end
            tick();
            check("t3_hold_data", DW'(data_out[0 +: W]), DW'(16'h3000));
            check("t3_hold_noclr", DW'(clr_bits), '0);
        end
        data_ready = 1'b1;
        tick();
        check("t3_drop", DW'(data_valid), '0);
        tick();
        check("t3_recap_clr", DW'(clr_bits), DW'(17'h1FFFF));
        check("t3_recap_data", DW'(data_out[5*W +: W]), DW'(16'h4005));
        fresh_bits = '0;
        repeat (2) tick();

        // 4: data entries fresh without VALID
        fresh_bits = {1'b0, {S{1'b1}}};
        for (int c = 0; c < 20; c++) begin
            set_words_rand();
            data_ready = 1'($urandom_range(0, 1));
            tick();
            check("t4_novalid", DW'(data_valid), '0);
        end

        // 5: asynchronous reset while holding
        data_ready = 1'b0;
        fresh_bits = {1'b1, {S{1'b0}}};
        tick();
        check("t5_pre_valid", DW'(data_valid), DW'(1));
        #2 rst = 1'b1;
        #1;
        check("t5_async_valid", DW'(data_valid), '0);
        check("t5_async_partial", DW'(partial), '0);
        check("t5_async_cnt", DW'(partial_cnt), '0);
        check("t5_async_clr", DW'(clr_bits), '0);
        fresh_bits = '0;
        @(negedge clk);
        do_reset();

        // random traffic
        for (int c = 0; c < 400; c++) begin
            set_words_rand();
            fresh_bits = (S+1)'({$urandom, $urandom});
            fresh_bits[S] = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) fresh_bits[S-1:0] = '1;
            data_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        data_ready = 1'b1;
        fresh_bits = '0;
        repeat (2) tick();

        // 6: counter saturation
        for (int c = 0; c < 300; c++) begin
            set_words_rand();
            fresh_bits = {1'b1, 1'b0, {(S-1){1'b1}}};
            tick();
            fresh_bits = '0;
            tick();
        end
        check("t6_saturated", DW'(partial_cnt), DW'(8'hFF));
        check("t6_commits_seen", DW'(commits > 300), DW'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
